// File: rtl/rst_seq_ctrl_if.sv
// Handshake bundle between the reset sequencer and the block that drives
// its release/ready inputs. "slave" is the sequencer's view and "master"
// is the view of whatever drives the inputs.
interface rst_seq_ctrl_if #(
  parameter int NUM_STAGES = 4
);
  logic                  rstbs_i;
  logic                  sw_rst_req;
  logic [NUM_STAGES-1:0] stage_rdy;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  seq_done;
  logic                  seq_err;
  logic [2:0]            state_o;
  logic [2:0]            stage_idx;

  modport master (
    output rstbs_i,
    output sw_rst_req,
    output stage_rdy,
    input  stage_rst_n,
    input  seq_done,
    input  seq_err,
    input  state_o,
    input  stage_idx
  );

  modport slave (
    input  rstbs_i,
    input  sw_rst_req,
    input  stage_rdy,
    output stage_rst_n,
    output seq_done,
    output seq_err,
    output state_o,
    output stage_idx
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Multi-stage reset release sequencer. Takes the synchronized release from
// the reset synchronizer and releases NUM_STAGES sub-block resets one at a
// time, waiting for each stage's ready (with a timeout) and inserting a gap
// before the next. A low release or a software request restarts everything.
// NUM_STAGES must match the NUM_STAGES of the connected interface.
module rst_seq_ctrl #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_DELAY = 16,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 8
) (
  input  logic          clk,
  input  logic          rst,
  rst_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_GAP      = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;

  // Terminal counts: each phase ends when the counter reaches its last value.
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [2:0]       LAST_STAGE   = 3'(NUM_STAGES - 1);

  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [NUM_STAGES-1:0] stage_rst_n_r;
  logic                  seq_done_r;
  logic                  seq_err_r;
  logic [2:0]            stage_idx_r;

  logic [NUM_STAGES-1:0] cur_mask_s;
  logic                  rdy_sel_s;

  // One-hot of the current stage and its ready bit; other stages' ready is ignored.
  always_comb begin
    cur_mask_s = '0;
    rdy_sel_s  = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      cur_mask_s[i] = (stage_idx_r == 3'(i));
      rdy_sel_s     = rdy_sel_s | (bus.stage_rdy[i] & cur_mask_s[i]);
    end
  end

  // Sequencer FSM with all outputs registered; release-low and software request override everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_HOLD;
      cnt_r         <= '0;
      stage_rst_n_r <= '0;
      seq_done_r    <= 1'b0;
      seq_err_r     <= 1'b0;
      stage_idx_r   <= 3'd0;
    end else if (!bus.rstbs_i || bus.sw_rst_req) begin
      state_r       <= ST_HOLD;
      cnt_r         <= '0;
      stage_rst_n_r <= '0;
      seq_done_r    <= 1'b0;
      seq_err_r     <= 1'b0;
      stage_idx_r   <= 3'd0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          // Release is high and no software request, so start settling.
          state_r <= ST_SETTLE;
          cnt_r   <= '0;
        end
        ST_SETTLE: begin
          if (cnt_r == HOLD_LAST) begin
            state_r <= ST_RELEASE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          stage_rst_n_r <= stage_rst_n_r | cur_mask_s;
          cnt_r         <= '0;
          state_r       <= ST_WAIT_RDY;
        end
        ST_WAIT_RDY: begin
          if (rdy_sel_s) begin
            cnt_r <= '0;
            if (stage_idx_r == LAST_STAGE) begin
              state_r    <= ST_DONE;
              seq_done_r <= 1'b1;
            end else begin
              state_r <= ST_GAP;
            end
          end else if (cnt_r == TIMEOUT_LAST) begin
            state_r   <= ST_ERROR;
            seq_err_r <= 1'b1;
            cnt_r     <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            stage_idx_r <= stage_idx_r + 3'd1;
            state_r     <= ST_RELEASE;
            cnt_r       <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DONE, ST_ERROR: begin
          // Terminal: outputs held until a re-sequence.
          state_r <= state_r;
        end
        default: begin
          // Unreachable encoding: fall back to the safe all-held state.
          state_r       <= ST_HOLD;
          cnt_r         <= '0;
          stage_rst_n_r <= '0;
          seq_done_r    <= 1'b0;
          seq_err_r     <= 1'b0;
          stage_idx_r   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.stage_rst_n = stage_rst_n_r;
  assign bus.seq_done    = seq_done_r;
  assign bus.seq_err     = seq_err_r;
  assign bus.state_o     = state_r;
  assign bus.stage_idx   = stage_idx_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with default parameters. Edge numbers
// follow the E0 convention: E0 is the first edge sampling rstbs_i=1.
module tb_rst_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   ecnt   = 0;

  rst_seq_ctrl_if #(.NUM_STAGES(4)) bus ();

  rst_seq_ctrl #(
    .NUM_STAGES (4),
    .HOLD_CYCLES(8),
    .STAGE_DELAY(16),
    .TIMEOUT    (64),
    .CNT_W      (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (E%0d)", tag, obs, exp, ecnt);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic run_to(input int e);
    while (ecnt < e) tick();
  endtask

  // Called between edges while in HOLD: the next edge becomes E0.
  task automatic arm(input logic [3:0] rdy);
    bus.stage_rdy = rdy;
    bus.rstbs_i   = 1'b1;
    ecnt          = -1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    bus.rstbs_i    = 1'b0;
    bus.sw_rst_req = 1'b0;
    bus.stage_rdy  = 4'h0;
    #12;
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_srn", 32'(bus.stage_rst_n), 32'h0);
    chk("rst_done", 32'(bus.seq_done), 32'd0);
    chk("rst_err", 32'(bus.seq_err), 32'd0);
    chk("rst_idx", 32'(bus.stage_idx), 32'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("hold_low_state", 32'(bus.state_o), 32'd0);

    // Nominal sequence, all stages ready.
    arm(4'hF);
    run_to(0);  chk("e0_settle", 32'(bus.state_o), 32'd1);
    run_to(7);  chk("e7_settle", 32'(bus.state_o), 32'd1);
    run_to(8);  chk("e8_release", 32'(bus.state_o), 32'd2);
                chk("e8_srn", 32'(bus.stage_rst_n), 32'h0);
    run_to(9);  chk("e9_srn", 32'(bus.stage_rst_n), 32'h1);
                chk("e9_wait", 32'(bus.state_o), 32'd3);
    run_to(10); chk("e10_gap", 32'(bus.state_o), 32'd4);
    run_to(26); chk("e26_srn", 32'(bus.stage_rst_n), 32'h1);
                chk("e26_idx", 32'(bus.stage_idx), 32'd1);
    run_to(27); chk("e27_srn", 32'(bus.stage_rst_n), 32'h3);
    run_to(44); chk("e44_srn", 32'(bus.stage_rst_n), 32'h3);
    run_to(45); chk("e45_srn", 32'(bus.stage_rst_n), 32'h7);
                chk("e45_idx", 32'(bus.stage_idx), 32'd2);
    run_to(62); chk("e62_srn", 32'(bus.stage_rst_n), 32'h7);
    run_to(63); chk("e63_srn", 32'(bus.stage_rst_n), 32'hF);
                chk("e63_done", 32'(bus.seq_done), 32'd0);
    run_to(64); chk("e64_done", 32'(bus.seq_done), 32'd1);
                chk("e64_state", 32'(bus.state_o), 32'd5);
                chk("e64_err", 32'(bus.seq_err), 32'd0);
    run_to(70); chk("done_hold", 32'(bus.seq_done), 32'd1);

    // One-cycle software request in DONE, then the sequence repeats.
    bus.sw_rst_req = 1'b1;
    tick();
    chk("sw_srn", 32'(bus.stage_rst_n), 32'h0);
    chk("sw_done", 32'(bus.seq_done), 32'd0);
    chk("sw_state", 32'(bus.state_o), 32'd0);
    bus.sw_rst_req = 1'b0;
    ecnt = -1;
    run_to(0);  chk("re_e0", 32'(bus.state_o), 32'd1);
    run_to(9);  chk("re_e9_srn", 32'(bus.stage_rst_n), 32'h1);
    run_to(27); chk("re_e27_srn", 32'(bus.stage_rst_n), 32'h3);
    run_to(30); chk("re_e30_gap", 32'(bus.state_o), 32'd4);

    // Release dropped mid-GAP.
    bus.rstbs_i = 1'b0;
    tick();
    chk("drop_state", 32'(bus.state_o), 32'd0);
    chk("drop_srn", 32'(bus.stage_rst_n), 32'h0);
    chk("drop_idx", 32'(bus.stage_idx), 32'd0);
    tick(); tick(); tick(); tick(); tick();
    chk("drop_stay", 32'(bus.state_o), 32'd0);

    // Stage 1 never ready -> timeout.
    arm(4'b1101);
    run_to(27); chk("to_e27_srn", 32'(bus.stage_rst_n), 32'h3);
                chk("to_e27_idx", 32'(bus.stage_idx), 32'd1);
    run_to(90); chk("to_e90_state", 32'(bus.state_o), 32'd3);
                chk("to_e90_err", 32'(bus.seq_err), 32'd0);
    run_to(91); chk("to_e91_state", 32'(bus.state_o), 32'd6);
                chk("to_e91_err", 32'(bus.seq_err), 32'd1);
                chk("to_e91_srn", 32'(bus.stage_rst_n), 32'h3);
                chk("to_e91_done", 32'(bus.seq_done), 32'd0);
    run_to(100); chk("to_hold_state", 32'(bus.state_o), 32'd6);
                 chk("to_hold_srn", 32'(bus.stage_rst_n), 32'h3);

    // Leave ERROR by software request, then async reset mid-WAIT_RDY.
    bus.sw_rst_req = 1'b1;
    tick();
    chk("err_exit_state", 32'(bus.state_o), 32'd0);
    chk("err_exit_err", 32'(bus.seq_err), 32'd0);
    bus.sw_rst_req = 1'b0;
    bus.stage_rdy  = 4'h0;
    ecnt = -1;
    run_to(12); chk("ar_wait_state", 32'(bus.state_o), 32'd3);
                chk("ar_wait_srn", 32'(bus.stage_rst_n), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_srn", 32'(bus.stage_rst_n), 32'h0);
    chk("ar_state", 32'(bus.state_o), 32'd0);
    bus.rstbs_i = 1'b0;
    #2;
    rst = 1'b0;
    tick(); tick();
    chk("ar_after_state", 32'(bus.state_o), 32'd0);

    // Early ready from unreleased stages is ignored; stage 0 ready after E20.
    arm(4'b1110);
    run_to(20); chk("er_e20_state", 32'(bus.state_o), 32'd3);
                chk("er_e20_srn", 32'(bus.stage_rst_n), 32'h1);
    bus.stage_rdy = 4'hF;
    run_to(21); chk("er_e21_gap", 32'(bus.state_o), 32'd4);
    run_to(37); chk("er_e37_srn", 32'(bus.stage_rst_n), 32'h1);
    run_to(38); chk("er_e38_srn", 32'(bus.stage_rst_n), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
